// File: rtl/axi_burst_wr_slave.sv
// AXI4 write-channel burst slave: one AW, awlen+1 W beats (no wlast), one B response.
// Beats land in a word-addressed byte-strobed register memory with a combinational read port.
module axi_burst_wr_slave #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDR_WIDTH-1:0]         s_axi_awaddr,
    input  logic [1:0]                    s_axi_awburst,
    input  logic [7:0]                    s_axi_awlen,
    input  logic [2:0]                    s_axi_awsize,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [DATA_WIDTH-1:0]         s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]       s_axi_wstrb,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    input  logic [$clog2(DEPTH)-1:0]      rd_addr,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          busy,
    output logic [15:0]                   burst_count
);

    localparam int unsigned PTR_W  = ADDR_WIDTH - 2;
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic [PTR_W-1:0] ptr;
    logic [7:0]       beats_left;
    logic [1:0]       mode;
    logic             err;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic w_fire;
    logic in_range;
    logic unused_bits;

    assign w_fire      = s_axi_wvalid && s_axi_wready;
    assign in_range    = 32'(ptr) < 32'(DEPTH);
    assign rd_data     = mem[rd_addr];
    // Beat size is fixed at one word, so awsize and the byte offset carry no information.
    assign unused_bits = &{1'b0, s_axi_awsize, s_axi_awaddr[1:0]};

    // Control FSM; every handshake output is a register so no input reaches a ready/valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            ptr           <= '0;
            beats_left    <= '0;
            mode          <= BURST_FIXED;
            err           <= 1'b0;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            busy          <= 1'b0;
            burst_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_axi_awvalid && s_axi_awready) begin
                        ptr           <= s_axi_awaddr[ADDR_WIDTH-1:2];
                        beats_left    <= s_axi_awlen;
                        mode          <= s_axi_awburst;
                        err           <= s_axi_awburst[1];
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b1;
                        busy          <= 1'b1;
                        state         <= DATA;
                    end
                end
                DATA: begin
                    if (w_fire) begin
                        if (!in_range) begin
                            err <= 1'b1;
                        end
                        if (mode != BURST_FIXED) begin
                            ptr <= ptr + PTR_W'(1);
                        end
                        if (beats_left == 8'd0) begin
                            s_axi_wready <= 1'b0;
                            s_axi_bvalid <= 1'b1;
                            s_axi_bresp  <= (err || !in_range) ? RESP_SLVERR : RESP_OKAY;
                            state        <= RESP;
                        end else begin
                            beats_left <= beats_left - 8'd1;
                        end
                    end
                end
                RESP: begin
                    if (s_axi_bvalid && s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        s_axi_bresp   <= RESP_OKAY;
                        s_axi_awready <= 1'b1;
                        busy          <= 1'b0;
                        burst_count   <= burst_count + 16'd1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state         <= IDLE;
                    s_axi_awready <= 1'b1;
                    s_axi_wready  <= 1'b0;
                    s_axi_bvalid  <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

    // Storage is deliberately not reset; out-of-range beats are dropped here.
    always_ff @(posedge clk) begin
        if (w_fire && in_range) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi_wstrb[b]) begin
                    mem[ptr[IDX_W-1:0]][8*b +: 8] <= s_axi_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule
